uart_tx_frame_serializer: RTL

//  Parametrised UART TX frame engine; successor to the bare data-bit shifter.

---
 rtl/uart_tx_frame_serializer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_frame_serializer.sv
// rtl/uart_tx_frame_serializer.sv - UART TX frame engine: start, data, optional parity, 1/2 stop bits
module uart_tx_frame_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  MSB_FIRST,
    input  logic                  STOP2,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  msb_q, msb_d;
    logic                  stop2_q, stop2_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  load;
    logic                  next_bit;
    logic [DATA_WIDTH-1:0] shifted;

    // The state names what is currently on the line; each edge moves to the next bit.
    assign next_bit = msb_q ? shreg_q[DATA_WIDTH-1] : shreg_q[0];
    assign shifted  = msb_q ? {shreg_q[DATA_WIDTH-2:0], 1'b0}
                            : {1'b0, shreg_q[DATA_WIDTH-1:1]};

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        msb_d      = msb_q;
        stop2_d    = stop2_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        load       = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d   = IDLE_LEVEL;
                busy_d = 1'b0;
                load   = Data_Valid;
            end
            S_START: begin
                tx_d    = next_bit;
                shreg_d = shifted;
                cnt_d   = '0;
                state_d = S_DATA;
            end
            S_DATA: begin
                if (cnt_q == LAST_BIT) begin
                    stop_cnt_d = 1'b0;
                    if (par_en_q) begin
                        tx_d    = par_bit_q;
                        state_d = S_PARITY;
                    end else begin
                        tx_d    = IDLE_LEVEL;
                        state_d = S_STOP;
                    end
                end else begin
                    tx_d    = next_bit;
                    shreg_d = shifted;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            S_PARITY: begin
                tx_d       = IDLE_LEVEL;
                stop_cnt_d = 1'b0;
                state_d    = S_STOP;
            end
            S_STOP: begin
                tx_d = IDLE_LEVEL;
                if (stop2_q && !stop_cnt_q) begin
                    stop_cnt_d = 1'b1;
                end else begin
                    // A request on the final stop edge starts the next frame with no gap.
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    load    = Data_Valid;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = IDLE_LEVEL;
                busy_d  = 1'b0;
            end
        endcase

        if (load) begin
            shreg_d    = P_DATA;
            par_en_d   = PAR_EN;
            par_bit_d  = (^P_DATA) ^ PAR_TYP;
            msb_d      = MSB_FIRST;
            stop2_d    = STOP2;
            stop_cnt_d = 1'b0;
            cnt_d      = '0;
            tx_d       = ~IDLE_LEVEL;
            busy_d     = 1'b1;
            state_d    = S_START;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            msb_q      <= 1'b0;
            stop2_q    <= 1'b0;
            stop_cnt_q <= 1'b0;
            tx_q       <= IDLE_LEVEL;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            msb_q      <= msb_d;
            stop2_q    <= stop2_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign TX_OUT     = tx_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule
